// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/ack data-memory port, store lane steering, load extension, timeout.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [2:0]       f3_q;

    logic        mem_op_c;
    logic        misalign_c;
    logic        timeout_c;
    logic [31:0] wdata_c;
    logic [3:0]  be_c;
    logic [31:0] ext_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign mem_op_c  = MemReadM | MemWriteM;
    assign StallM    = ((state == IDLE) && mem_op_c) || (state == BUSY);
    assign timeout_c = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MISALIGN_TRAP_EN
    // Halves need a[0]=0, words (and illegal widths treated as words) need a[1:0]=0
    always_comb begin
        case (funct3M[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = ALUResultM[0];
            default: misalign_c = (ALUResultM[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane replication and byte enables; loads always read the full word
    always_comb begin
        case (funct3M[1:0])
            2'b00: begin
                wdata_c = {4{WriteDataM[7:0]}};
                be_c    = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                wdata_c = {2{WriteDataM[15:0]}};
                be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_c = WriteDataM;
                be_c    = 4'b1111;
            end
        endcase
        if (!MemWriteM) be_c = 4'b1111;
    end

    // Load lane select and sign/zero extension from the registered offset and width
    always_comb begin
        case (lane_q)
            2'd0:    byte_c = dmem_rdata[7:0];
            2'd1:    byte_c = dmem_rdata[15:8];
            2'd2:    byte_c = dmem_rdata[23:16];
            default: byte_c = dmem_rdata[31:24];
        endcase
        half_c = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  ext_c = {24'h0, byte_c};
            3'b101:  ext_c = {16'h0, half_c};
            default: ext_c = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lane_q     <= 2'b00;
            f3_q       <= 3'b000;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
            ReadDataM  <= 32'h0;
            BusErrM    <= 1'b0;
            MisalignM  <= 1'b0;
        end else begin
            BusErrM   <= 1'b0;
            MisalignM <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op_c) begin
                        if (misalign_c) begin
                            ReadDataM <= 32'h0;
                            MisalignM <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= MemWriteM;
                            dmem_addr  <= {ALUResultM[31:2], 2'b00};
                            dmem_wdata <= wdata_c;
                            dmem_be    <= be_c;
                            lane_q     <= ALUResultM[1:0];
                            f3_q       <= funct3M;
                            cnt        <= '0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the final allowed cycle still completes normally
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        ReadDataM <= dmem_we ? 32'h0 : ext_c;
                        state     <= DONE;
                    end else if (timeout_c) begin
                        dmem_req  <= 1'b0;
                        ReadDataM <= 32'h0;
                        BusErrM   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver queues expected requests/completions, monitor compares.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b000;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM, MisalignM;

    mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
        .BusErrM(BusErrM), .MisalignM(MisalignM)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; logic mis; int stalls; int reqs; } cpl_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } req_t;

    cpl_t cpl_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;

    int          ack_waits = 0;
    logic        ack_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic        mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_waits wait states while a request is pending
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hFFFF_FFFF;
            end else if (dmem_req && ack_en) begin
                if (wcnt == ack_waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = resp_rdata;
                end else begin
                    dmem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Issue one memory instruction (called just after a posedge) and hold it until it advances
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic ack_ok,
                          input logic [31:0] rv, input logic trap,
                          input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewdata, input logic [31:0] erd, input logic eerr);
        cpl_t c;
        req_t r;
        int   n;
        c.reqs   = trap ? 0 : (ack_ok ? waits + 1 : TO);
        c.stalls = trap ? 1 : c.reqs + 1;
        c.rdata  = erd;
        c.err    = eerr;
        c.mis    = trap;
        cpl_q.push_back(c);
        if (!trap) begin
            r.addr = eaddr; r.we = wr; r.wdata = ewdata; r.be = ebe;
            req_q.push_back(r);
        end
        ack_waits  = waits;
        ack_en     = ack_ok;
        resp_rdata = rv;
        MemReadM   = !wr;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (StallM && n < 40);
        if (StallM) begin
            checks++;
            errors++;
            $display("FAIL advance_timeout: StallM still %b after %0d cycles, required 0", StallM, n);
        end
        @(posedge clk);
        #1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    // Monitor: checks requests on first visibility, stability while held, and completions
    initial begin
        int   st = 0, rq = 0;
        logic prev_req = 1'b0;
        req_t cap;
        cpl_t c;
        cap = '{32'h0, 1'b0, 32'h0, 4'h0};
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (MemReadM || MemWriteM) begin
                    if (StallM) st++;
                    if (dmem_req) begin
                        rq++;
                        if (!prev_req) begin
                            if (req_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_req: got addr %h, required no request", dmem_addr);
                            end else begin
                                cap = req_q.pop_front();
                                chk("req_addr", dmem_addr, cap.addr);
                                chk("req_we", 32'(dmem_we), 32'(cap.we));
                                chk("req_be", 32'(dmem_be), 32'(cap.be));
                                if (cap.we) chk("req_wdata", dmem_wdata, cap.wdata);
                            end
                        end else begin
                            chk("req_addr_stable", dmem_addr, cap.addr);
                            chk("req_be_stable", 32'(dmem_be), 32'(cap.be));
                            if (cap.we) chk("req_wdata_stable", dmem_wdata, cap.wdata);
                        end
                    end
                    if (!StallM) begin
                        if (cpl_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got completion, required none");
                        end else begin
                            c = cpl_q.pop_front();
                            chk("read_data", ReadDataM, c.rdata);
                            chk("bus_err", 32'(BusErrM), 32'(c.err));
                            chk("misalign", 32'(MisalignM), 32'(c.mis));
                            chk("stall_cycles", 32'(st), 32'(c.stalls));
                            chk("req_cycles", 32'(rq), 32'(c.reqs));
                        end
                        st = 0;
                        rq = 0;
                    end
                end else begin
                    chk("idle_stall", 32'(StallM), 32'h0);
                    chk("idle_req", 32'(dmem_req), 32'h0);
                    chk("idle_flags", 32'({BusErrM, MisalignM}), 32'h0);
                end
                prev_req = dmem_req;
            end else begin
                st = 0;
                rq = 0;
                prev_req = 1'b0;
            end
        end
    end

    initial begin
        #12;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be", 32'(dmem_be), 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_flags", 32'({BusErrM, MisalignM, StallM, dmem_we}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        //      wr  f3      addr          wdata         w  ack   rdata         trap  eaddr         ebe      ewdata        erd           err
        access(0, 3'b010, 32'h0000_0100, 32'h0,        0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0);
        access(0, 3'b000, 32'h0000_0103, 32'h0,        1, 1'b1, 32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hFFFF_FF80, 1'b0);
        access(0, 3'b100, 32'h0000_0103, 32'h0,        0, 1'b1, 32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h0000_0080, 1'b0);
        @(posedge clk); #1;
        access(0, 3'b001, 32'h0000_0102, 32'h0,        2, 1'b1, 32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hFFFF_80FF, 1'b0);
        access(0, 3'b101, 32'h0000_0100, 32'h0,        0, 1'b1, 32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h0000_FF7F, 1'b0);
        access(0, 3'b000, 32'h0000_0100, 32'h0,        0, 1'b1, 32'h80FF_FF7F, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h0000_007F, 1'b0);
        access(0, 3'b010, 32'h0000_0300, 32'h0,        0, 1'b0, 32'h0,         1'b0, 32'h0000_0300, 4'hF, 32'h0,        32'h0,         1'b1);
        @(posedge clk); #1;
        access(0, 3'b011, 32'h0000_0104, 32'h0,        0, 1'b1, 32'h1122_3344, 1'b0, 32'h0000_0104, 4'hF, 32'h0,        32'h1122_3344, 1'b0);
        access(1, 3'b000, 32'h0000_0201, 32'h1234_5678, 3, 1'b1, 32'h0,        1'b0, 32'h0000_0200, 4'h2, 32'h7878_7878, 32'h0,         1'b0);
        access(1, 3'b001, 32'h0000_0202, 32'h1234_5678, 0, 1'b1, 32'h0,        1'b0, 32'h0000_0200, 4'hC, 32'h5678_5678, 32'h0,         1'b0);
        access(0, 3'b010, 32'h0000_0108, 32'h0,        3, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0000_0108, 4'hF, 32'h0,        32'h0BAD_F00D, 1'b0);
        access(1, 3'b010, 32'h0000_020C, 32'hCAFE_F00D, 1, 1'b1, 32'h0,        1'b0, 32'h0000_020C, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0);
`ifdef MISALIGN_TRAP_EN
        access(1, 3'b010, 32'h0000_0102, 32'hA5A5_A5A5, 0, 1'b1, 32'h0,        1'b1, 32'h0,         4'h0, 32'h0,        32'h0,         1'b0);
        access(0, 3'b001, 32'h0000_0101, 32'h0,        0, 1'b1, 32'h1234_ABCD, 1'b1, 32'h0,         4'h0, 32'h0,        32'h0,         1'b0);
`else
        access(1, 3'b010, 32'h0000_0102, 32'hA5A5_A5A5, 0, 1'b1, 32'h0,        1'b0, 32'h0000_0100, 4'hF, 32'hA5A5_A5A5, 32'h0,         1'b0);
        access(0, 3'b001, 32'h0000_0101, 32'h0,        0, 1'b1, 32'h1234_ABCD, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hFFFF_ABCD, 1'b0);
`endif
        access(0, 3'b010, 32'h0000_0108, 32'h0,        0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0000_0108, 4'hF, 32'h0,        32'h0BAD_F00D, 1'b0);

        // Reset asserted while a request is outstanding, followed by a stray ack
        @(posedge clk); #1;
        mon_en     = 1'b0;
        ack_en     = 1'b0;
        MemReadM   = 1'b1;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0400;
        @(posedge clk); #1;
        chk("rst_mid_req_before", 32'(dmem_req), 32'h1);
        #2;
        rst_n    = 1'b0;
        MemReadM = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'h0);
        chk("rst_mid_rdata", ReadDataM, 32'h0);
        chk("rst_mid_addr", dmem_addr, 32'h0);
        chk("rst_mid_stall", 32'(StallM), 32'h0);
        force_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_ack_req", 32'(dmem_req), 32'h0);
        chk("late_ack_rdata", ReadDataM, 32'h0);
        chk("late_ack_outs", 32'({StallM, BusErrM, MisalignM, dmem_we, dmem_be}), 32'h0);
        force_ack = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        access(0, 3'b100, 32'h0000_0502, 32'h0,        0, 1'b1, 32'h00C3_0000, 1'b0, 32'h0000_0500, 4'hF, 32'h0,        32'h0000_00C3, 1'b0);

        repeat (3) @(posedge clk);
        chk("cpl_queue_empty", 32'(cpl_q.size()), 32'h0);
        chk("req_queue_empty", 32'(req_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
